// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter sharing the regfile write port between two writeback requesters
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_reg,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_reg,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  RegWrite,
    output logic [ADDR_WIDTH-1:0] WriteRegister,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  last_grant
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    // Low for the reset cycles and the first cycle after release, so no
    // request is granted until the arbiter has seen one clean edge.
    logic active;

    logic grant0;
    logic grant1;

    // One-hot grant: a lone requester wins outright, a contest goes to the
    // index that did not win last time.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (active && !reset) begin
            if (req0_valid && req1_valid) begin
                if (last_grant) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Register the accepted write; zero-register writes are consumed but
    // never raise the write enable. Idle cycles hold index/data/pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            active        <= 1'b0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            last_grant    <= 1'b1;
        end else begin
            active   <= 1'b1;
            RegWrite <= 1'b0;
            if (grant0) begin
                WriteRegister <= req0_reg;
                WriteData     <= req0_data;
                RegWrite      <= (req0_reg != ZERO_IDX);
                last_grant    <= 1'b0;
            end else if (grant1) begin
                WriteRegister <= req1_reg;
                WriteData     <= req1_data;
                RegWrite      <= (req1_reg != ZERO_IDX);
                last_grant    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid;
    logic [4:0]  req0_reg;
    logic [63:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_reg;
    logic [63:0] req1_data;
    logic        req1_ready;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic        last_grant;

    int errors = 0;
    int checks = 0;

    logic [63:0] regfile [32];

    regfile_write_arbiter #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(5),
        .ZERO_REG(31)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req0_valid(req0_valid),
        .req0_reg(req0_reg),
        .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_reg(req1_reg),
        .req1_data(req1_data),
        .req1_ready(req1_ready),
        .RegWrite(RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData(WriteData),
        .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    // Reference regfile consuming the registered write port.
    always @(posedge clk) begin
        if (RegWrite && WriteRegister != 5'd31) begin
            regfile[WriteRegister] <= WriteData;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regfile[i] = '0;

        // 1: reset held two cycles with both requesters valid
        reset = 1'b1;
        req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 64'd1;
        req1_valid = 1'b1; req1_reg = 5'd4; req1_data = 64'd2;
        tick();
        #1;
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        tick();
        check("rst_regwrite", RegWrite, 0);
        check("rst_wreg", WriteRegister, 0);
        check("rst_wdata", WriteData, 0);
        check("rst_last_grant", last_grant, 1);
        reset = 1'b0;
        #1;
        check("post_rst_ready0", req0_ready, 0);
        check("post_rst_ready1", req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check("post_rst_regwrite", RegWrite, 0);

        // 2: single req0 write
        req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 64'hA5;
        #1;
        check("single_ready0", req0_ready, 1);
        check("single_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        check("single_regwrite", RegWrite, 1);
        check("single_wreg", WriteRegister, 5);
        check("single_wdata", WriteData, 64'hA5);
        check("single_last_grant", last_grant, 0);
        tick();
        check("single_idle_regwrite", RegWrite, 0);
        check("single_idle_wreg_hold", WriteRegister, 5);
        check("single_idle_grant_hold", last_grant, 0);

        // 3: continuous contention from a fresh reset alternates 0,1,0,...
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 64'd1;
        req1_valid = 1'b1; req1_reg = 5'd4; req1_data = 64'd2;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("cont_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
            check("cont_ready1", req1_ready, (i % 2 == 0) ? 0 : 1);
            tick();
            check("cont_regwrite", RegWrite, 1);
            check("cont_wreg", WriteRegister, (i % 2 == 0) ? 3 : 4);
            check("cont_wdata", WriteData, (i % 2 == 0) ? 1 : 2);
            check("cont_last_grant", last_grant, (i % 2 == 0) ? 0 : 1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check("cont_x3", regfile[3], 1);
        check("cont_x4", regfile[4], 2);

        // 4: zero-register write is consumed but suppressed
        req1_valid = 1'b1; req1_reg = 5'd31; req1_data = 64'hFF;
        #1;
        check("zero_ready1", req1_ready, 1);
        check("zero_ready0", req0_ready, 0);
        tick();
        req1_valid = 1'b0;
        check("zero_regwrite", RegWrite, 0);
        check("zero_last_grant", last_grant, 1);
        check("zero_wreg", WriteRegister, 31);
        tick();
        check("zero_idle_regwrite", RegWrite, 0);

        // 5: both target X7 after reset; req0's 10 then req1's 20
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        req0_valid = 1'b1; req0_reg = 5'd7; req0_data = 64'd10;
        req1_valid = 1'b1; req1_reg = 5'd7; req1_data = 64'd20;
        #1;
        check("same_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        check("same_first_wdata", WriteData, 10);
        check("same_first_regwrite", RegWrite, 1);
        #1;
        check("same_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        check("same_second_wdata", WriteData, 20);
        check("same_second_wreg", WriteRegister, 7);
        tick();
        check("same_x7_final", regfile[7], 20);

        // 6: reset lands on the edge that would register the X9 write
        req0_valid = 1'b1; req0_reg = 5'd9; req0_data = 64'h99;
        #1;
        check("midrst_ready0", req0_ready, 1);
        reset = 1'b1;
        #1;
        check("midrst_ready0_gated", req0_ready, 0);
        tick();
        req0_valid = 1'b0;
        check("midrst_regwrite", RegWrite, 0);
        check("midrst_wreg", WriteRegister, 0);
        check("midrst_last_grant", last_grant, 1);
        reset = 1'b0;
        tick();
        tick();
        check("midrst_regwrite_after", RegWrite, 0);
        check("midrst_x9_untouched", regfile[9], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
